// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with a one-entry skid buffer.
// o_ready_M comes straight from a flop, so WB backpressure never reaches MEM combinationally.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid_M,
  output logic              o_ready_M,
  input  logic [DATA_W-1:0] alu_data_M,
  input  logic [DATA_W-1:0] read_data_M,
  input  logic [DATA_W-1:0] pc_four_M,
  input  logic [ADDR_W-1:0] rd_addr_M,
  input  logic [SEL_W-1:0]  wb_sel_M,
  input  logic              rd_wren_M,
  output logic              o_valid_W,
  input  logic              i_ready_W,
  output logic [DATA_W-1:0] alu_data_W,
  output logic [DATA_W-1:0] read_data_W,
  output logic [DATA_W-1:0] pc_four_W,
  output logic [ADDR_W-1:0] rd_addr_W,
  output logic [SEL_W-1:0]  wb_sel_W,
  output logic              rd_wren_W,
  output logic [1:0]        o_count
);

  localparam int PAY_W = 3 * DATA_W + ADDR_W + SEL_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_r;
  logic [PAY_W-1:0]   main_r;
  logic [PAY_W-1:0]   skid_r;
  logic               main_valid_r;
  logic               skid_valid_r;
  logic               ready_r;
  logic               wren_out_r;
  logic [1:0]         count_r;
  logic [PAY_W-1:0]   pay_in_s;
  logic               accept_s;
  logic               consume_s;

  assign pay_in_s  = {alu_data_M, read_data_M, pc_four_M, rd_addr_M, wb_sel_M, rd_wren_M};
  assign accept_s  = i_valid_M & ready_r;
  assign consume_s = main_valid_r & i_ready_W;

  // Occupancy FSM; the rd_wren output flop is cleared whenever main goes invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= EMPTY;
      main_r       <= {PAY_W{1'b0}};
      skid_r       <= {PAY_W{1'b0}};
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
      wren_out_r   <= 1'b0;
      count_r      <= 2'd0;
    end else if (i_flush) begin
      state_r      <= EMPTY;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
      wren_out_r   <= 1'b0;
      count_r      <= 2'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_r       <= pay_in_s;
            main_valid_r <= 1'b1;
            wren_out_r   <= rd_wren_M;
            count_r      <= 2'd1;
            state_r      <= ONE;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          if (accept_s && consume_s) begin
            main_r     <= pay_in_s;
            wren_out_r <= rd_wren_M;
          end else if (accept_s) begin
            skid_r       <= pay_in_s;
            skid_valid_r <= 1'b1;
            ready_r      <= 1'b0;
            count_r      <= 2'd2;
            state_r      <= FULL;
          end else if (consume_s) begin
            main_valid_r <= 1'b0;
            wren_out_r   <= 1'b0;
            count_r      <= 2'd0;
            state_r      <= EMPTY;
          end else begin
            state_r <= ONE;
          end
        end
        FULL: begin
          if (consume_s) begin
            main_r       <= skid_r;
            wren_out_r   <= skid_r[0];
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
            count_r      <= 2'd1;
            state_r      <= ONE;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          main_valid_r <= 1'b0;
          skid_valid_r <= 1'b0;
          ready_r      <= 1'b1;
          wren_out_r   <= 1'b0;
          count_r      <= 2'd0;
          state_r      <= EMPTY;
        end
      endcase
    end
  end

  assign o_ready_M = ready_r;
  assign o_valid_W = main_valid_r;
  assign rd_wren_W = wren_out_r;
  assign o_count   = count_r;
  assign {alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W} = main_r[PAY_W-1:1];

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: stream, backpressure, bubble, flush and async reset.
module tb_wb_pipe_reg;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid_M;
  logic        o_ready_M;
  logic [31:0] alu_data_M, read_data_M, pc_four_M;
  logic [4:0]  rd_addr_M;
  logic [1:0]  wb_sel_M;
  logic        rd_wren_M;
  logic        o_valid_W;
  logic        i_ready_W;
  logic [31:0] alu_data_W, read_data_W, pc_four_W;
  logic [4:0]  rd_addr_W;
  logic [1:0]  wb_sel_W;
  logic        rd_wren_W;
  logic [1:0]  o_count;

  int vectors = 0;
  int miscompares = 0;

  wb_pipe_reg dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid_M(i_valid_M), .o_ready_M(o_ready_M),
    .alu_data_M(alu_data_M), .read_data_M(read_data_M), .pc_four_M(pc_four_M),
    .rd_addr_M(rd_addr_M), .wb_sel_M(wb_sel_M), .rd_wren_M(rd_wren_M),
    .o_valid_W(o_valid_W), .i_ready_W(i_ready_W),
    .alu_data_W(alu_data_W), .read_data_W(read_data_W), .pc_four_W(pc_four_W),
    .rd_addr_W(rd_addr_W), .wb_sel_W(wb_sel_W), .rd_wren_W(rd_wren_W),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // Status bundle {valid, ready, count, wren} for compact comparisons.
  logic [4:0] status;
  assign status = {o_valid_W, o_ready_M, o_count, rd_wren_W};

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic w);
    i_valid_M   = v;
    alu_data_M  = a;
    read_data_M = a + 32'h100;
    pc_four_M   = a << 2;
    rd_addr_M   = a[4:0];
    wb_sel_M    = a[1:0];
    rd_wren_M   = w;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_flush = 1'b0; i_ready_W = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    vectors++;
    if ({status, alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W} !== {5'b01000, 103'd0}) begin
      miscompares++;
      $display("FAIL reset: status=%b alu=%h rd=%h pc=%h addr=%h sel=%h, required status=01000 data 0",
               status, alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    i_ready_W = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, k, 1'b1);
      step();
      vectors++;
      if ({status, alu_data_W} !== {5'b11011, 32'(k)}) begin
        miscompares++;
        $display("FAIL stream[%0d]: status=%b alu=%h, required status=11011 alu=%h", k, status, alu_data_W, k);
      end
    end
    vectors++;
    if ({read_data_W, pc_four_W, rd_addr_W, wb_sel_W} !== {32'h104, 32'h10, 5'd4, 2'd0}) begin
      miscompares++;
      $display("FAIL stream_fields: rd=%h pc=%h addr=%h sel=%h, required 104 10 04 0",
               read_data_W, pc_four_W, rd_addr_W, wb_sel_W);
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    vectors++;
    if (status !== 5'b01000) begin
      miscompares++;
      $display("FAIL stream_drain: status=%b, required 01000", status);
    end
  endtask

  task automatic test_backpressure();
    i_ready_W = 1'b0;
    drive(1'b1, 32'hA, 1'b1);
    step();
    vectors++;
    if ({status, alu_data_W} !== {5'b11011, 32'hA}) begin
      miscompares++;
      $display("FAIL bp_first: status=%b alu=%h, required 11011 0000000a", status, alu_data_W);
    end
    drive(1'b1, 32'hB, 1'b0);
    step();
    vectors++;
    if ({status, alu_data_W} !== {5'b10101, 32'hA}) begin
      miscompares++;
      $display("FAIL bp_full: status=%b alu=%h, required 10101 0000000a", status, alu_data_W);
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    vectors++;
    if ({status, alu_data_W, read_data_W} !== {5'b10101, 32'hA, 32'h10A}) begin
      miscompares++;
      $display("FAIL bp_hold: status=%b alu=%h rd=%h, required 10101 0000000a 0000010a",
               status, alu_data_W, read_data_W);
    end
    i_ready_W = 1'b1;
    step();
    vectors++;
    if ({status, alu_data_W} !== {5'b11010, 32'hB}) begin
      miscompares++;
      $display("FAIL bp_pop_a: status=%b alu=%h, required 11010 0000000b", status, alu_data_W);
    end
    step();
    vectors++;
    if (status !== 5'b01000) begin
      miscompares++;
      $display("FAIL bp_pop_b: status=%b, required 01000", status);
    end
  endtask

  task automatic test_bubble();
    i_ready_W = 1'b1;
    drive(1'b1, 32'h3, 1'b1);
    step();
    vectors++;
    if ({status, rd_addr_W} !== {5'b11011, 5'd3}) begin
      miscompares++;
      $display("FAIL bubble_load: status=%b addr=%h, required 11011 03", status, rd_addr_W);
    end
    drive(1'b0, 32'h0, 1'b1);
    step();
    vectors++;
    if ({o_valid_W, rd_wren_W} !== 2'b00) begin
      miscompares++;
      $display("FAIL bubble: valid=%b wren=%b, required 0 0", o_valid_W, rd_wren_W);
    end
  endtask

  task automatic test_flush();
    i_ready_W = 1'b0;
    drive(1'b1, 32'hA, 1'b1); step();
    drive(1'b1, 32'hB, 1'b1); step();
    vectors++;
    if (o_count !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_fill: count=%0d, required 2", o_count);
    end
    i_ready_W = 1'b1;
    i_flush = 1'b1;
    drive(1'b1, 32'hC, 1'b1);
    step();
    vectors++;
    if (status !== 5'b01000) begin
      miscompares++;
      $display("FAIL flush: status=%b, required 01000", status);
    end
    i_flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({o_valid_W, rd_wren_W} !== 2'b00) begin
        miscompares++;
        $display("FAIL flush_ghost[%0d]: valid=%b wren=%b alu=%h, required 0 0", k, o_valid_W, rd_wren_W, alu_data_W);
      end
    end
    drive(1'b1, 32'hE, 1'b1);
    step();
    vectors++;
    if ({status, alu_data_W} !== {5'b11011, 32'hE}) begin
      miscompares++;
      $display("FAIL flush_after: status=%b alu=%h, required 11011 0000000e", status, alu_data_W);
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_async_reset();
    i_ready_W = 1'b0;
    drive(1'b1, 32'h11, 1'b1); step();
    drive(1'b1, 32'h22, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if (status !== 5'b10101) begin
      miscompares++;
      $display("FAIL arst_fill: status=%b, required 10101", status);
    end
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({status, alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W} !== {5'b01000, 103'd0}) begin
      miscompares++;
      $display("FAIL arst_mid: status=%b alu=%h, required status 01000 data 0", status, alu_data_W);
    end
    step();
    i_rst_n = 1'b1;
    i_ready_W = 1'b1;
    drive(1'b1, 32'hD, 1'b1);
    step();
    vectors++;
    if ({status, alu_data_W} !== {5'b11011, 32'hD}) begin
      miscompares++;
      $display("FAIL arst_after: status=%b alu=%h, required 11011 0000000d", status, alu_data_W);
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    vectors++;
    if (status !== 5'b01000) begin
      miscompares++;
      $display("FAIL arst_drain: status=%b, required 01000", status);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
